// File: rtl/rs_pkg.sv
// Shared RS(255,239) GF(2^8) constants and constant-multiply helpers for the
// encoder, syndrome, Chien and Forney blocks.
package rs_pkg;
  localparam int         RS_W    = 8;
  localparam int         RS_T    = 8;
  localparam int         RS_N    = 255;
  localparam int         RS_K    = 239;
  localparam logic [8:0] RS_POLY = 9'h11D;

  typedef enum logic {S_IDLE, S_ACCUM} syn_state_e;

  // b * lambda^j, lambda = 0x02; with constant j this flattens to an XOR net
  function automatic logic [RS_W-1:0] gf_mul_const(input logic [RS_W-1:0] b, input int j);
    logic [RS_W-1:0] v;
    v = b;
    for (int i = 0; i < RS_N; i++)
      if (i < j) v = {v[RS_W-2:0], 1'b0} ^ (v[RS_W-1] ? RS_POLY[RS_W-1:0] : '0);
    return v;
  endfunction

  function automatic logic [RS_W-1:0] gf_alpha_pow(input int j);
    return gf_mul_const(8'h01, j);
  endfunction
endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator S_J: load on sop, Horner step S*lambda^J ^ d otherwise.
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int J = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            acc_i,
  input  logic [RS_W-1:0] data_i,
  output logic [RS_W-1:0] syn_nxt_o
);
  logic [RS_W-1:0] syn_q, syn_d;

  always_comb begin
    syn_d = syn_q;
    if (load_i)     syn_d = data_i;
    else if (acc_i) syn_d = gf_mul_const(syn_q, J) ^ data_i;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) syn_q <= '0;
    else       syn_q <= syn_d;

  // next value feeds the hold bank so the eop byte lands in the same edge
  assign syn_nxt_o = syn_d;
endmodule

// File: rtl/rs_syndrome.sv
// RS(255,239) syndrome front end: byte-serial Horner accumulation of 2T syndromes,
// hold bank drained j=0..2T-1 over valid/ready. Optional length check: RS_SYN_LEN_CHECK_EN.
module rs_syndrome
  import rs_pkg::*;
#(
  parameter int W     = 8,
  parameter int T     = 8,
  parameter int N_MAX = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic         in_eop,
  output logic         in_ready,
  output logic [W-1:0] out_syn,
  output logic [3:0]   out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_err
`ifdef RS_SYN_LEN_CHECK_EN
  ,output logic        len_err,
  output logic [7:0]   abort_cnt
`endif
);
  localparam int NS = 2*T;

  // the 8-bit length counter cannot represent larger frames
  if (N_MAX > 255) begin : g_nmax_unsupported
  end

  syn_state_e            state_q, state_d;
  logic [NS-1:0][W-1:0]  nxt, hold_q;
  logic                  hold_full_q, err_q;
  logic [3:0]            idx_q;
  logic                  accept, load, acc, eop_acc, drain, last;

  assign in_ready = ~(hold_full_q & in_valid & in_eop);
  assign accept   = in_valid & in_ready;
  assign load     = accept & in_sop;
  assign acc      = accept & ~in_sop & (state_q == S_ACCUM);
  assign eop_acc  = (load | acc) & in_eop;
  assign drain    = hold_full_q & out_ready;
  assign last     = drain & (idx_q == 4'(NS-1));

  for (genvar j = 0; j < NS; j++) begin : g_cell
    rs_syn_cell #(.J(j)) u_cell (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load),
      .acc_i     (acc),
      .data_i    (in_data),
      .syn_nxt_o (nxt[j])
    );
  end

  always_comb begin
    state_d = state_q;
    if (eop_acc)   state_d = S_IDLE;
    else if (load) state_d = S_ACCUM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q <= state_d;
      if (eop_acc) begin
        hold_q      <= nxt;
        err_q       <= |nxt;
        hold_full_q <= 1'b1;
      end else if (last) begin
        hold_full_q <= 1'b0;
      end
      if (last)       idx_q <= '0;
      else if (drain) idx_q <= idx_q + 4'd1;
    end
  end

  assign out_valid = hold_full_q;
  assign out_idx   = idx_q;
  assign out_syn   = hold_full_q ? hold_q[idx_q] : '0;
  assign out_err   = err_q;

`ifdef RS_SYN_LEN_CHECK_EN
  logic [7:0] cnt_q, cnt_d, abort_q;
  logic       ovf_q, ovf_d, len_err_q, len_bad;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (load) begin
      cnt_d = 8'd1;
      ovf_d = 1'b0;
    end else if (acc) begin
      if (cnt_q == 8'hFF) ovf_d = 1'b1;
      else                cnt_d = cnt_q + 8'd1;
    end
    len_bad = ovf_d | (int'(cnt_d) > N_MAX) | (int'(cnt_d) < NS+1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      len_err_q <= 1'b0;
      abort_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (eop_acc)   len_err_q <= len_bad;
      else if (last) len_err_q <= 1'b0;
      if (load && state_q == S_ACCUM && abort_q != 8'hFF) abort_q <= abort_q + 8'd1;
    end
  end

  assign len_err   = len_err_q;
  assign abort_cnt = abort_q;
`endif
endmodule

// File: tb/tb_rs_syndrome.sv
// Directed bench for rs_syndrome: table of frames with hand-derived syndromes,
// plus encoder codeword, overlap/backpressure, reset and restart sequences.
module tb_rs_syndrome;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_sop, in_eop, in_ready;
  logic [7:0] out_syn;
  logic [3:0] out_idx;
  logic       out_valid, out_ready, out_err;
`ifdef RS_SYN_LEN_CHECK_EN
  logic       len_err;
  logic [7:0] abort_cnt;
`endif

  always #5 clk = ~clk;

  rs_syndrome dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .out_syn(out_syn), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_err(out_err)
`ifdef RS_SYN_LEN_CHECK_EN
    , .len_err(len_err), .abort_cnt(abort_cnt)
`endif
  );

  int         checks = 0, errors = 0;
  logic [7:0] fb [0:299];
  logic       fsop [0:299];
  logic       feop [0:299];
  logic [7:0] exp_s [16];
  logic [7:0] gen [0:16];
  logic [7:0] par [16];

  typedef struct {
    int               len;
    logic [7:0]       fill;
    int               pos;
    logic [7:0]       val;
    logic [15:0][7:0] exp;
    logic             exp_err;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] lpow(input int e);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < e; i++) v = gmul(v, 8'h02);
    return v;
  endfunction

  task automatic model(input int start, input int n);
    for (int j = 0; j < 16; j++) begin
      logic [7:0] s, l;
      s = 8'h00; l = lpow(j);
      for (int i = 0; i < n; i++) s = gmul(s, l) ^ fb[start+i];
      exp_s[j] = s;
    end
  endtask

  function automatic logic any_nz();
    logic r;
    r = 1'b0;
    for (int j = 0; j < 16; j++) r |= (exp_s[j] != 8'h00);
    return r;
  endfunction

  task automatic set_frame(input int n, input logic [7:0] fill);
    for (int i = 0; i < 300; i++) begin
      fb[i] = (i < n) ? fill : 8'h00;
      fsop[i] = (i == 0);
      feop[i] = (i == n-1);
    end
  endtask

  // entered and left at posedge+1
  task automatic send_byte(input int i);
    int   k;
    logic r;
    in_data = fb[i]; in_sop = fsop[i]; in_eop = feop[i]; in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1; k++;
    end while (!r && k < 200);
    if (!r) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) send_byte(i);
  endtask

  task automatic collect(input string name, input logic exp_err);
    for (int k = 0; k < 16; k++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      if (!out_valid) begin
        chk({name, "_valid_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        return;
      end
      chk({name, "_idx"}, 32'(out_idx), k);
      chk({name, "_syn"}, 32'(out_syn), 32'(exp_s[k]));
      if (k == 0) chk({name, "_err"}, 32'(out_err), 32'(exp_err));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({name, "_drained"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_b [16];
    logic [7:0] fbk;

    vecs[0] = '{255, 8'h00, 254, 8'h00, '0, 1'b0};
    vecs[1] = '{255, 8'h00, 254, 8'h01, {16{8'h01}}, 1'b1};
    vecs[2] = '{2, 8'h00, 0, 8'h01,
                {8'h26,8'h13,8'h87,8'hCD,8'hE8,8'h74,8'h3A,8'h1D,
                 8'h80,8'h40,8'h20,8'h10,8'h08,8'h04,8'h02,8'h01}, 1'b1};
    vecs[3] = '{1, 8'h00, 0, 8'h37, {16{8'h37}}, 1'b1};
    // 255 ones: sum of lambda^(j*i) over a full cycle vanishes except for j=0
    vecs[4] = '{255, 8'h01, 0, 8'h01, {{15{8'h00}}, 8'h01}, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = 8'h00; out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx",   32'(out_idx),   0);
    chk("rst_syn",   32'(out_syn),   0);
    chk("rst_err",   32'(out_err),   0);
    chk("rst_ready", 32'(in_ready),  1);
    @(posedge clk); #1; reset = 1'b0;

    // table-driven frames
    for (int v = 0; v < 5; v++) begin
      set_frame(vecs[v].len, vecs[v].fill);
      fb[vecs[v].pos] = vecs[v].val;
      send_range(0, vecs[v].len);
      chk($sformatf("vec%0d_latency", v), 32'(out_valid), 1);
      for (int j = 0; j < 16; j++) exp_s[j] = vecs[v].exp[j];
      collect($sformatf("vec%0d", v), vecs[v].exp_err);
    end

    // systematic codeword from a reference encoder, generator roots lambda^0..15
    for (int i = 0; i < 17; i++) gen[i] = (i == 0) ? 8'h01 : 8'h00;
    for (int j = 0; j < 16; j++) begin
      logic [7:0] r;
      r = lpow(j);
      for (int i = 16; i >= 0; i--) gen[i] = ((i > 0) ? gen[i-1] : 8'h00) ^ gmul(gen[i], r);
    end
    set_frame(255, 8'h00);
    for (int j = 0; j < 16; j++) par[j] = 8'h00;
    for (int i = 0; i < 239; i++) begin
      fb[i] = 8'($urandom_range(0, 255));
      fbk = fb[i] ^ par[15];
      for (int j = 15; j > 0; j--) par[j] = par[j-1] ^ gmul(fbk, gen[j]);
      par[0] = gmul(fbk, gen[0]);
    end
    for (int j = 0; j < 16; j++) fb[239+j] = par[15-j];
    send_range(0, 255);
    for (int j = 0; j < 16; j++) exp_s[j] = 8'h00;
    collect("codeword", 1'b0);

    // single error 0x5A at degree 254-100 = 154: S_j = 0x5A * lambda^(154 j)
    fb[100] ^= 8'h5A;
    send_range(0, 255);
    for (int j = 0; j < 16; j++) exp_s[j] = gmul(8'h5A, lpow((154*j) % 255));
    collect("flip", 1'b1);

    // overlap: frame A held by out_ready=0, 20-byte frame B stalls only on eop
    out_ready = 1'b0;
    set_frame(2, 8'h00); fb[0] = 8'h01;
    send_range(0, 2);
    set_frame(20, 8'h00);
    for (int i = 0; i < 20; i++) fb[i] = 8'(i*7 + 3);
    model(0, 20);
    for (int j = 0; j < 16; j++) exp_b[j] = exp_s[j];
    for (int i = 0; i < 19; i++) begin
      in_data = fb[i]; in_sop = fsop[i]; in_eop = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      if (i == 0 || i == 18) chk($sformatf("ovl_accept%0d", i), 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_data = fb[19]; in_sop = 1'b0; in_eop = 1'b1; in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("ovl_a_valid", 32'(out_valid), 1);
      chk("ovl_a_idx",   32'(out_idx), k);
      chk("ovl_a_syn",   32'(out_syn), 32'(vecs[2].exp[k]));
      chk("ovl_stall",   32'(in_ready), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ovl_release", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_eop = 1'b0;
    chk("ovl_b_latency", 32'(out_valid), 1);
    for (int j = 0; j < 16; j++) exp_s[j] = exp_b[j];
    collect("ovl_b", any_nz());

    // reset with a full hold bank and a partial frame in flight
    out_ready = 1'b0;
    set_frame(2, 8'h00); fb[0] = 8'h01;
    send_range(0, 2);
    set_frame(30, 8'h00);
    for (int i = 0; i < 30; i++) fb[i] = 8'(8'hC3 ^ (i*13));
    send_range(0, 10);
    reset = 1'b1; #2;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_idx",   32'(out_idx),   0);
    chk("mid_rst_syn",   32'(out_syn),   0);
    chk("mid_rst_err",   32'(out_err),   0);
    chk("mid_rst_ready", 32'(in_ready),  1);
    @(posedge clk); #1; reset = 1'b0; out_ready = 1'b1;
    send_range(0, 30);
    model(0, 30);
    collect("post_rst", any_nz());

    // restart: second sop at byte 50 drops the first 50 bytes
    set_frame(60, 8'h00);
    for (int i = 0; i < 60; i++) fb[i] = 8'(i ^ 8'hA5);
    fsop[50] = 1'b1;
    send_range(0, 59);
    chk("restart_no_out", 32'(out_valid), 0);
    send_byte(59);
    model(50, 10);
    collect("restart", any_nz());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_syndrome.md
Name: rs_syndrome

Overview:
- Receive-side front end of the RS(255,239,T=8) decoder over GF(2^8).
- Field polynomial p(x)=x^8+x^4+x^3+x^2+1 (0x11D); λ=0x02.
- Accepts a byte-serial received codeword, which may be shortened, and computes the 2T=16 syndromes S_j=r(λ^j), j=0..15, by Horner accumulation.
- Streams the syndromes to the downstream key-equation solver with a valid/ready handshake and flags nonzero syndromes as error-present.

Parameters:
- W, 8, symbol width in bits.
- T, 8, correctable symbols; 2T syndromes are produced.
- N_MAX, 255, maximum codeword length in bytes; used only by the optional length check.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_data  in  W  received symbol; the first byte is the highest-degree coefficient.
- in_valid  in  1  in_data is valid.
- in_sop  in  1  first byte of a codeword; qualified by in_valid.
- in_eop  in  1  last byte of a codeword; qualified by in_valid.
- in_ready  out  1  byte accepted when in_valid&in_ready.
- out_syn  out  W  syndrome value.
- out_idx  out  4  syndrome index j.
- out_valid  out  1  out_syn/out_idx valid.
- out_ready  in  1  downstream accepts the syndrome.
- out_err  out  1  OR of all 16 syndromes of the current set; stable while out_valid.

Behaviour:
- States: IDLE, ACCUM.
  - IDLE: an accepted byte with in_sop loads S_j<=in_data for all j, then goes to ACCUM.
  - IDLE: an accepted byte without in_sop is discarded.
- ACCUM: each accepted byte updates S_j<=S_j·λ^j ⊕ in_data.
  - The multiply is a constant multiply mod 0x11D, purely combinational.
- sop while in ACCUM: restarts accumulation. The partial codeword is dropped and no output is produced for it.
- sop&eop on the same byte: a 1-byte codeword, S_j=in_data.
- Accepted eop: the final S_j values are copied into a 16-entry hold bank on the same edge, hold_full<=1, state returns to IDLE.
- Output latency: out_valid rises the cycle after the eop beat.
- Output order: j=0..15, one per accepted handshake.
  - out_idx increments on out_valid&out_ready.
  - After the j=15 handshake, hold_full<=0 and out_valid<=0.
- Hold values are stable while out_valid&~out_ready.
- out_err is registered at hold-bank load: 1 iff any S_j≠0.
- in_ready = ~(hold_full & in_valid & in_eop).
  - The next codeword can accumulate fully while the previous syndromes drain; only its eop beat stalls.
  - A j=15 handshake in the same cycle does not release the stall; release happens the following cycle.
- Overlap rule: with hold_full=1, bytes without eop are accepted normally.
- Reset, including mid-frame: state=IDLE, all S_j=0, hold bank=0, hold_full=0, out_valid=0, out_idx=0, out_syn=0, out_err=0, in_ready=1 (as evaluated with in_valid=0).
- Widths: all arithmetic is GF(2^8) (XOR / constant mult); there are no integer carries.

Optional Feature:
- Macro: RS_SYN_LEN_CHECK_EN.
- When defined:
  - An 8-bit byte counter runs in ACCUM.
  - Output port len_err (1 bit) is registered at hold-bank load. It is 1 if the codeword length exceeds N_MAX or is below 2T+1.
  - len_err is cleared with hold_full.
  - A restart by mid-frame sop pulses an internal abort counter, readable on port abort_cnt (8 bits, saturating).
- When undefined: neither port exists, there is no counter logic, and behaviour is otherwise identical.

Decomposition:
- Package rs_pkg holds:
  - constants RS_W=8, RS_T=8, RS_N=255, RS_K=239, RS_POLY=9'h11D;
  - function gf_mul_const(byte, j), which returns byte·λ^j;
  - function gf_alpha_pow(j).
- The package is shared with the encoder and the future Chien/Forney blocks.
- Sub-module rs_syn_cell, parameterized by J: holds one S_j register, with load/accumulate inputs and the constant multiply. It is instantiated 16× via generate.

Test Plan:
- Zeros: 255 zero bytes, sop on byte 0, eop on byte 254, out_ready=1.
  - Expect 16 outputs, all out_syn=0x00, out_err=0, out_idx 0..15, first out_valid one cycle after eop.
- Position zero: 255 bytes, all zero except the last = 0x01.
  - Expect S_j=0x01 for all j, out_err=1.
- Power check: 2-byte codeword {0x01,0x00}.
  - Expect S_0..S_9 = 01,02,04,08,10,20,40,80,1D,3A; S_10..S_15 continue λ^j (74,E8,CD,87,13,26); out_err=1.
- Valid codeword: feed a codeword from the encoder reference model, random 239 info bytes plus 16 parity.
  - Expect all S_j=0, out_err=0.
  - Then flip byte 100 by 0x5A: expect nonzero syndromes matching the model, out_err=1.
- Backpressure/overlap: hold out_ready=0 after the first eop, send a 20-byte second codeword.
  - 19 bytes are accepted; the eop beat sees in_ready=0.
  - Release out_ready: after S_15 drains, the eop is accepted the next cycle and the second set is correct.
- Reset/restart:
  - Assert reset mid-ACCUM: outputs are at reset values and a following complete codeword is correct.
  - Separately, a sop at byte 50 of a frame: no output for the aborted frame; the output matches the restarted frame only.
